uart_rx_fifo: RTL and testbench

//  Byte FIFO downstream of the UART receiver. Buffers bytes pushed on each RX-done strobe so

---
 rtl/uart_rx_fifo.sv | 116 +++++++++++
 tb/tb_uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : First-word-fall-through byte FIFO behind the UART receiver,
//                with full/empty/level status and a sticky overflow flag.
//                Optional dropped-push counter: define UART_FIFO_DROP_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    input  logic              i_clr_overflow,
    output logic [7:0]        o_drop_cnt
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_pop  = i_rd_en && !w_empty;
    assign w_push = i_wr_en && (!w_full || w_pop);
    assign w_drop = i_wr_en && !w_push;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
            // Setting wins over clearing when both happen together.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef UART_FIFO_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_cnt <= 8'd0;
        end else if (w_drop && i_clr_overflow) begin
            r_drop_cnt <= 8'd1;
        end else if (w_drop) begin
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (i_clr_overflow) begin
            r_drop_cnt <= 8'd0;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    assign o_drop_cnt = 8'd0;
`endif

    assign o_rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_rd_valid = !w_empty;
    assign o_empty    = w_empty;
    assign o_full     = w_full;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       i_wr_en;
    logic [7:0] i_wr_data;
    logic       i_rd_en;
    logic [7:0] o_rd_data;
    logic       o_rd_valid;
    logic       o_empty;
    logic       o_full;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       i_clr_overflow;
    logic [7:0] o_drop_cnt;

    int vectors;
    int miscompares;

    uart_rx_fifo #(
        .DATA_W (8),
        .DEPTH  (16),
        .ADDR_W (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_wr_en        (i_wr_en),
        .i_wr_data      (i_wr_data),
        .i_rd_en        (i_rd_en),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_count        (o_count),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow),
        .o_drop_cnt     (o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drop count after one dropped push from a cleared counter.
`ifdef UART_FIFO_DROP_CNT_EN
    localparam logic [7:0] c_drop_one = 8'd1;
    localparam logic [7:0] c_drop_two = 8'd2;
`else
    localparam logic [7:0] c_drop_one = 8'd0;
    localparam logic [7:0] c_drop_two = 8'd0;
`endif

    initial begin
        logic [7:0] nexp;
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b0;
        i_wr_en        = 1'b1;
        i_wr_data      = 8'h77;
        i_rd_en        = 1'b0;
        i_clr_overflow = 1'b0;

        // Reset held with a push request active
        tick();
        tick();
        chk("rst_empty", o_empty, 1);
        chk("rst_count", o_count, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_valid", o_rd_valid, 0);
        chk("rst_data", o_rd_data, 0);
        chk("rst_full", o_full, 0);
        chk("rst_drop", o_drop_cnt, 0);
        reset   = 1'b1;
        i_wr_en = 1'b0;
        tick();

        // Single byte latency
        i_wr_en   = 1'b1;
        i_wr_data = 8'hA5;
        tick();
        i_wr_en = 1'b0;
        chk("one_valid", o_rd_valid, 1);
        chk("one_data", o_rd_data, 8'hA5);
        chk("one_count", o_count, 1);
        i_rd_en = 1'b1;
        tick();
        chk("one_pop_empty", o_empty, 1);
        chk("one_pop_data", o_rd_data, 0);

        // Pop while empty is ignored
        tick();
        i_rd_en = 1'b0;
        chk("epop_count", o_count, 0);
        chk("epop_empty", o_empty, 1);
        chk("epop_ovf", o_overflow, 0);

        // Fill, overflow, drain
        i_wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_wr_data = 8'(i);
            tick();
        end
        chk("fill_full", o_full, 1);
        chk("fill_count", o_count, 16);
        chk("fill_ovf", o_overflow, 0);
        i_wr_data = 8'h55;
        tick();
        i_wr_en = 1'b0;
        chk("drop_ovf", o_overflow, 1);
        chk("drop_cnt", o_drop_cnt, c_drop_one);
        chk("drop_count", o_count, 16);
        chk("drop_head", o_rd_data, 8'h00);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", o_rd_data, 32'(i));
            i_rd_en = 1'b1;
            tick();
        end
        i_rd_en = 1'b0;
        chk("drain_empty", o_empty, 1);
        chk("drain_ovf_sticky", o_overflow, 1);
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        chk("clr_ovf", o_overflow, 0);
        chk("clr_drop", o_drop_cnt, 0);

        // Pointer wrap with streaming push/pop at level 2
        nexp    = 8'h10;
        i_wr_en = 1'b1;
        i_wr_data = 8'h10;
        tick();
        i_wr_data = 8'h11;
        tick();
        i_rd_en = 1'b1;
        for (int k = 8'h12; k <= 8'h37; k++) begin
            i_wr_data = 8'(k);
            chk("wrap_data", o_rd_data, nexp);
            chk("wrap_count", o_count, 2);
            nexp = nexp + 8'd1;
            tick();
        end
        i_wr_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("wrap_tail", o_rd_data, nexp);
            nexp = nexp + 8'd1;
            tick();
        end
        i_rd_en = 1'b0;
        chk("wrap_empty", o_empty, 1);
        chk("wrap_seen", nexp, 8'h38);

        // Full with simultaneous push and pop
        i_wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_wr_data = 8'hC0 + 8'(i);
            tick();
        end
        i_wr_data = 8'hEE;
        i_rd_en   = 1'b1;
        tick();
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        chk("fpp_count", o_count, 16);
        chk("fpp_full", o_full, 1);
        chk("fpp_ovf", o_overflow, 0);
        chk("fpp_head", o_rd_data, 8'hC1);
        i_rd_en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("fpp_drain", o_rd_data, 32'h00C0 + 32'(i));
            tick();
        end
        chk("fpp_last", o_rd_data, 8'hEE);
        tick();
        chk("fpp_empty", o_empty, 1);

        // Empty with simultaneous push and pop
        i_wr_en   = 1'b1;
        i_wr_data = 8'h3C;
        tick();
        i_rd_en = 1'b0;
        i_wr_en = 1'b0;
        chk("epp_count", o_count, 1);
        chk("epp_head", o_rd_data, 8'h3C);
        chk("epp_valid", o_rd_valid, 1);

        // Reset at level 7
        i_wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_wr_data = 8'h90 + 8'(i);
            tick();
        end
        i_wr_en = 1'b0;
        chk("lvl7_count", o_count, 7);
        reset   = 1'b0;
        i_wr_en = 1'b1;
        i_rd_en = 1'b1;
        tick();
        reset   = 1'b1;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        chk("mrst_empty", o_empty, 1);
        chk("mrst_count", o_count, 0);
        chk("mrst_data", o_rd_data, 0);

        // Drop coinciding with clear keeps the flag set
        i_wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            i_wr_data = 8'h20 + 8'(i);
            tick();
        end
        i_wr_data      = 8'hFF;
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        chk("setclr_ovf", o_overflow, 1);
        chk("setclr_drop", o_drop_cnt, c_drop_one);
        tick();
        i_wr_en = 1'b0;
        chk("drop2_ovf", o_overflow, 1);
        chk("drop2_cnt", o_drop_cnt, c_drop_two);
        chk("drop2_head", o_rd_data, 8'h20);
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        chk("clr2_ovf", o_overflow, 0);
        chk("clr2_drop", o_drop_cnt, 0);
        chk("clr2_count", o_count, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
